// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Fetch-side front end of the pipelined RISC-V core. Owns the fetch PC,
//   issues one word request at a time to a variable-latency instruction
//   memory, and buffers returned {pc, instr} pairs in a small FIFO that the
//   IF stage drains under its IF/ID write enable. A branch redirect from ID
//   flushes the queue and discards any stale in-flight response.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/addr  : word request to instruction memory (addr = fetch PC)
//   req_ready       : memory accepts the request this cycle
//   resp_valid/data : memory returns the instruction for the outstanding request
//   out_valid/pc/instr : queue head (pc=0, instr=NOP_INSTR when empty)
//   out_ready       : IF stage consumes the head this cycle
//   redirect_valid/pc : flush and restart fetch at redirect_pc (word aligned)
//   q_count         : FIFO occupancy (debug)
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int unsigned      Nbits     = 64,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [Nbits-1:0] RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       req_valid,
    output logic [Nbits-1:0]           req_addr,
    input  logic                       req_ready,
    input  logic                       resp_valid,
    input  logic [31:0]                resp_data,
    output logic                       out_valid,
    output logic [Nbits-1:0]           out_pc,
    output logic [31:0]                out_instr,
    input  logic                       out_ready,
    input  logic                       redirect_valid,
    input  logic [Nbits-1:0]           redirect_pc,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {
        S_ISSUE = 1'b0,
        S_WAIT  = 1'b1
    } state_t;

    typedef struct packed {
        logic [Nbits-1:0] pc;
        logic [31:0]      instr;
    } fetchEntry_t;

    state_t            state;
    logic [Nbits-1:0]  fetchPc;
    logic [Nbits-1:0]  pendingPc;
    logic              dropResp;
    logic              fetchEnable;
    logic [PtrW-1:0]   rdPtr;
    logic [PtrW-1:0]   wrPtr;
    logic [CntW-1:0]   count;
    fetchEntry_t       entries [DEPTH];
    fetchEntry_t       headEntry;

    logic              reqFire;
    logic              respFire;
    logic              doPush;
    logic              doPop;
    logic              hasSpace;

    // Handshake and FIFO strobes
    always_comb begin
        hasSpace = (count < CntW'(DEPTH));
        reqFire  = req_valid & req_ready;
        respFire = (state == S_WAIT) & resp_valid;
        doPush   = respFire & ~dropResp & ~redirect_valid;
        doPop    = out_ready & out_valid & ~redirect_valid;
    end

    // Request side: a request is only offered when the response is guaranteed
    // a slot, so the FIFO can never overflow. fetchEnable holds req_valid low
    // for the reset cycle itself.
    assign req_valid = fetchEnable & (state == S_ISSUE) & hasSpace;
    assign req_addr  = fetchPc;

    // Head presentation
    assign headEntry = entries[rdPtr];
    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? headEntry.pc    : '0;
    assign out_instr = out_valid ? headEntry.instr : NOP_INSTR;
    assign q_count   = count;

    // Fetch FSM, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_ISSUE;
            fetchPc     <= RESET_PC;
            pendingPc   <= '0;
            dropResp    <= 1'b0;
            fetchEnable <= 1'b0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetchEnable <= 1'b1;
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            fetchPc     <= redirect_pc & ~Nbits'(3);
            if (respFire) begin
                // Outstanding response lands in the redirect cycle: it is
                // discarded here, so nothing remains in flight to wait for.
                state    <= S_ISSUE;
                dropResp <= 1'b0;
            end else if ((state == S_WAIT) || reqFire) begin
                // A stale response is still coming; swallow it when it arrives.
                state    <= S_WAIT;
                dropResp <= 1'b1;
            end else begin
                // Unaccepted request is simply retracted.
                state    <= S_ISSUE;
            end
        end else begin
            fetchEnable <= 1'b1;
            case (state)
                S_ISSUE: begin
                    if (reqFire) begin
                        pendingPc <= fetchPc;
                        fetchPc   <= fetchPc + Nbits'(4);
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        dropResp <= 1'b0;
                        state    <= S_ISSUE;
                    end
                end
                default: state <= S_ISSUE;
            endcase

            if (doPush) wrPtr <= wrPtr + PtrW'(1);
            if (doPop)  rdPtr <= rdPtr + PtrW'(1);

            case ({doPush, doPop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage (no reset needed: entries are only read when counted valid)
    always_ff @(posedge clk) begin
        if (doPush) begin
            entries[wrPtr] <= '{pc: pendingPc, instr: resp_data};
        end
    end

    // The space check at issue time makes a push into a full queue impossible
    assert property (@(posedge clk) disable iff (rst)
        !(doPush && (count == CntW'(DEPTH))));

endmodule
